// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Load-use hazard sequencer for the 5-stage core. Inserts a single bubble on a
// load-use dependency and then hands a registered forward-from-MEM select to
// the forwarding path. Freezes the pipe while data memory is busy, flushes on
// taken branches and raises a sticky flag when a memory access times out.
// Build option: define HAZARD_STALL_COUNT_EN to build the saturating
// stall-cycle counter; otherwise stall_cycles is tied to zero.
module hazard_stall_controller #(
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_ra_used,
  input  logic             id_rb_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_load,
  input  logic             ex_valid,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             fwd_a_mem,
  output logic             fwd_b_mem,
  output logic             mem_err,
  output logic [15:0]      stall_cycles
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fwd_a_q, fwd_a_d;
  logic       fwd_b_q, fwd_b_d;
  logic       mem_err_q, mem_err_d;

  logic       match_a, match_b, hazard_lu, mem_stall;
  logic       stall_front, stall_back, flush_front, flush_back;

  assign match_a   = id_ra_used & (id_ra == ex_rd);
  assign match_b   = id_rb_used & (id_rb == ex_rd);
  assign hazard_lu = ex_valid & ex_load & (match_a | match_b);
  assign mem_stall = mem_req & ~mem_ready;

  // Next-state and same-cycle stall/flush decode; priority mem > branch > load-use.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    wait_cnt_d  = wait_cnt_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    mem_err_d   = mem_err_q;
    stall_front = 1'b0;
    stall_back  = 1'b0;
    flush_front = 1'b0;
    flush_back  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          stall_front = 1'b1;
          stall_back  = 1'b1;
          ret_d       = RUN;
          wait_cnt_d  = 8'd1;
          state_d     = MEM_WAIT;
        end else if (branch_taken) begin
          // The ID instruction is squashed, so any load-use hazard is moot.
          flush_front = 1'b1;
          flush_back  = 1'b1;
          fwd_a_d     = 1'b0;
          fwd_b_d     = 1'b0;
        end else if (hazard_lu) begin
          stall_front = 1'b1;
          flush_back  = 1'b1;
          fwd_a_d     = match_a;
          fwd_b_d     = match_b;
          state_d     = LU_BUBBLE;
        end else begin
          fwd_a_d     = 1'b0;
          fwd_b_d     = 1'b0;
        end
      end
      LU_BUBBLE: begin
        if (mem_stall) begin
          // Forward selects stay latched until the bubble actually advances.
          stall_front = 1'b1;
          stall_back  = 1'b1;
          ret_d       = LU_BUBBLE;
          wait_cnt_d  = 8'd1;
          state_d     = MEM_WAIT;
        end else if (branch_taken) begin
          flush_front = 1'b1;
          flush_back  = 1'b1;
          fwd_a_d     = 1'b0;
          fwd_b_d     = 1'b0;
          state_d     = RUN;
        end else begin
          fwd_a_d     = 1'b0;
          fwd_b_d     = 1'b0;
          state_d     = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          wait_cnt_d  = 8'd0;
          state_d     = ret_q;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          // Give up on the access: release the pipe and drop any pending forward.
          mem_err_d   = 1'b1;
          wait_cnt_d  = 8'd0;
          fwd_a_d     = 1'b0;
          fwd_b_d     = 1'b0;
          state_d     = RUN;
        end else begin
          stall_front = 1'b1;
          stall_back  = 1'b1;
          wait_cnt_d  = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        fwd_a_d     = 1'b0;
        fwd_b_d     = 1'b0;
        wait_cnt_d  = 8'd0;
        state_d     = RUN;
      end
    endcase
  end

  // Sequencer state, return state, wait counter, forward selects and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ret_q      <= RUN;
      wait_cnt_q <= 8'd0;
      fwd_a_q    <= 1'b0;
      fwd_b_q    <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Combinational controls are forced low while reset is asserted.
  assign stall_pc    = rst_n & stall_front;
  assign stall_ifid  = rst_n & stall_front;
  assign stall_idex  = rst_n & stall_back;
  assign stall_exmem = rst_n & stall_back;
  assign flush_ifid  = rst_n & flush_front;
  assign flush_idex  = rst_n & flush_back;
  assign fwd_a_mem   = fwd_a_q;
  assign fwd_b_mem   = fwd_b_q;
  assign mem_err     = mem_err_q;

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_pc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller. A behavioural reference
// model predicts every output for each cycle; predictions are queued when the
// stimulus is applied and popped for comparison at the falling clock edge.
module tb_hazard_stall_controller;

  localparam int REG_W = 4;
  localparam int TO    = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [REG_W-1:0] id_ra = '0, id_rb = '0, ex_rd = '0;
  logic id_ra_used = 1'b0, id_rb_used = 1'b0, ex_load = 1'b0, ex_valid = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex;
  logic fwd_a_mem, fwd_b_mem, mem_err;
  logic [15:0] stall_cycles;

  hazard_stall_controller #(.REG_W(REG_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .ex_rd(ex_rd),
    .ex_load(ex_load), .ex_valid(ex_valid), .mem_req(mem_req),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a_mem(fwd_a_mem), .fwd_b_mem(fwd_b_mem), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [25:0] exp_q[$];

  // Reference model state: 0=RUN 1=LU_BUBBLE 2=MEM_WAIT
  int m_st, m_ret, m_wc, m_cnt;
  bit m_fa, m_fb, m_err;
  int n_st, n_ret, n_wc, n_cnt;
  bit n_fa, n_fb, n_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] observed();
    return {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
            fwd_a_mem, fwd_b_mem, mem_err, stall_cycles};
  endfunction

  task automatic model_reset();
    m_st = 0; m_ret = 0; m_wc = 0; m_cnt = 0;
    m_fa = 1'b0; m_fb = 1'b0; m_err = 1'b0;
  endtask

  // Predict this cycle's outputs from model state and current inputs, and the next state.
  task automatic model_eval(output logic [25:0] e);
    bit ma, mb, hz, ms, sf, sb, ff, fb;
    int cnt_out;
    ma = id_ra_used && (id_ra == ex_rd);
    mb = id_rb_used && (id_rb == ex_rd);
    hz = ex_valid && ex_load && (ma || mb);
    ms = mem_req && !mem_ready;
    sf = 0; sb = 0; ff = 0; fb = 0;
    n_st = m_st; n_ret = m_ret; n_wc = m_wc; n_fa = m_fa; n_fb = m_fb; n_err = m_err;
    if (m_st == 2) begin
      if (mem_ready) begin
        n_st = m_ret; n_wc = 0;
      end else if (m_wc == TO) begin
        n_err = 1; n_st = 0; n_wc = 0; n_fa = 0; n_fb = 0;
      end else begin
        sf = 1; sb = 1; n_wc = m_wc + 1;
      end
    end else if (ms) begin
      sf = 1; sb = 1; n_ret = m_st; n_wc = 1; n_st = 2;
    end else if (branch_taken) begin
      ff = 1; fb = 1; n_fa = 0; n_fb = 0; n_st = 0;
    end else if (m_st == 0 && hz) begin
      sf = 1; fb = 1; n_fa = ma; n_fb = mb; n_st = 1;
    end else begin
      n_fa = 0; n_fb = 0; n_st = 0;
    end
    n_cnt = (sf && m_cnt != 65535) ? m_cnt + 1 : m_cnt;
`ifdef HAZARD_STALL_COUNT_EN
    cnt_out = m_cnt;
`else
    cnt_out = 0;
`endif
    e = {sf, sf, sb, sb, ff, fb, m_fa, m_fb, m_err, cnt_out[15:0]};
  endtask

  task automatic cyc(input string tag, input int ra, input int rb, input bit rau, input bit rbu,
                     input int rd, input bit ld, input bit vld, input bit mreq, input bit mrdy,
                     input bit br);
    logic [25:0] e;
    id_ra = ra[REG_W-1:0]; id_rb = rb[REG_W-1:0]; id_ra_used = rau; id_rb_used = rbu;
    ex_rd = rd[REG_W-1:0]; ex_load = ld; ex_valid = vld;
    mem_req = mreq; mem_ready = mrdy; branch_taken = br;
    model_eval(e);
    exp_q.push_back(e);
    @(negedge clk);
    check_val(tag, {6'd0, observed()}, {6'd0, exp_q.pop_front()});
    m_st = n_st; m_ret = n_ret; m_wc = n_wc; m_fa = n_fa; m_fb = n_fb; m_err = n_err;
    m_cnt = n_cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outputs", {6'd0, observed()}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Load-use on RA, then bubble, then clear
    cyc("lu_ra", 7, 1, 1, 1, 7, 1, 1, 0, 1, 0);
    idle(3);
    // Load-use on RB only
    cyc("lu_rb", 7, 1, 1, 1, 1, 1, 1, 0, 1, 0);
    idle(2);
    // Same operands, not a load
    cyc("no_load", 7, 1, 1, 1, 1, 0, 1, 0, 1, 0);
    idle(1);
    // Matching index but operand unused
    cyc("unused", 5, 5, 0, 0, 5, 1, 1, 0, 1, 0);
    // Hazard plus taken branch: flush only
    cyc("lu_branch", 5, 0, 1, 0, 5, 1, 1, 0, 1, 1);
    idle(1);
    // Load-use, then memory stall inside the bubble
    cyc("lu_then_mw", 3, 3, 1, 1, 3, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("lu_mw_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("lu_mw_release", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    // Fresh hazard in the bubble cycle is not evaluated
    cyc("lu_bubble_hz", 2, 0, 1, 0, 2, 1, 1, 0, 1, 0);
    idle(2);

    // Memory timeout
    for (int i = 0; i < 20; i++) cyc("timeout", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 300; i++)
      cyc("rand", $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 7) == 0));

    // Reset pulse clears sticky error
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_val("err_cleared", {6'd0, observed()}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Load-use plus 3-cycle memory wait, then async reset mid-wait
    cyc("cnt_lu", 9, 0, 1, 0, 9, 1, 1, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc("cnt_mw", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("cnt_release", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("cnt_total", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw_again", 4, 0, 1, 0, 4, 1, 1, 1, 0, 0);
    cyc("mw_again2", 4, 0, 1, 0, 4, 1, 1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("async_reset", {6'd0, observed()}, 32'd0);
    @(posedge clk);
    #1;
    check_val("reset_hold", {6'd0, observed()}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard sequencer for the 5-stage core.
- Sits beside the MEM-stage forwarding unit. Detects load-use hazards between the ID-stage operands and the load in EX, then inserts one bubble.
- After the bubble, it hands a registered forward-from-MEM select to the forwarding path, so RA/RB take the loaded value.
- Also freezes the whole pipe while data memory is not ready, flushes on taken branches, and flags memory timeouts.

Parameters:
- REG_W, 4, register index width (16 architectural registers, all forwardable, no hardwired zero).
- TIMEOUT, 15, max MEM_WAIT cycles before mem_err; legal range 1..255.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_ra  in  REG_W  ID-stage source register A.
- id_rb  in  REG_W  ID-stage source register B.
- id_ra_used  in  1  instruction in ID reads RA.
- id_rb_used  in  1  instruction in ID reads RB.
- ex_rd  in  REG_W  EX-stage destination register.
- ex_load  in  1  EX instruction is a memory load.
- ex_valid  in  1  EX holds a valid (non-bubble) instruction.
- mem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- branch_taken  in  1  EX resolved a taken branch.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID register.
- stall_idex  out  1  hold ID/EX register.
- stall_exmem  out  1  hold EX/MEM register.
- flush_ifid  out  1  zero IF/ID on next edge.
- flush_idex  out  1  insert bubble into ID/EX on next edge.
- fwd_a_mem  out  1  registered: operand A takes MEM load data.
- fwd_b_mem  out  1  registered: operand B takes MEM load data.
- mem_err  out  1  sticky memory timeout flag.
- stall_cycles  out  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=RUN, ret_state=RUN, wait_cnt=0, fwd_a_mem=fwd_b_mem=0, mem_err=0, stall_cycles=0. Combinational outputs evaluate to 0 while in reset.
- hazard_lu = ex_valid & ex_load & ((id_ra_used & id_ra==ex_rd) | (id_rb_used & id_rb==ex_rd)).
- mem_stall = mem_req & ~mem_ready.
- Stall/flush outputs are combinational from state and inputs (same-cycle response). fwd_* and mem_err are registered.
- Priority in RUN and LU_BUBBLE: mem_stall > branch_taken > hazard_lu.
- RUN:
  - mem_stall: all four stall_* =1. ret_state<=RUN, wait_cnt<=1, next MEM_WAIT.
  - branch_taken: flush_ifid=flush_idex=1, stay RUN. hazard_lu is ignored because the ID instruction is squashed.
  - hazard_lu: stall_pc=stall_ifid=1, flush_idex=1. fwd_a_mem<=id_ra_used&(id_ra==ex_rd), fwd_b_mem<=id_rb_used&(id_rb==ex_rd). Next LU_BUBBLE.
  - otherwise: no action; fwd_* <=0.
- LU_BUBBLE (exactly one pipeline-advancing cycle; fwd_* held high as latched):
  - mem_stall: all stall_* =1, ret_state<=LU_BUBBLE, wait_cnt<=1, next MEM_WAIT; fwd_* retained.
  - branch_taken: flush_ifid=flush_idex=1, fwd_* <=0, next RUN.
  - otherwise: next RUN, fwd_* <=0. A fresh hazard_lu in this cycle is not evaluated; it is handled in RUN the next cycle.
- MEM_WAIT:
  - All stall_* =1 while mem_ready=0. branch_taken and hazard_lu are ignored; fwd_* are frozen.
  - mem_ready=1: stalls drop the same cycle, next=ret_state, wait_cnt<=0.
  - wait_cnt==TIMEOUT and mem_ready=0: mem_err<=1 (sticky until reset), stalls drop that cycle, next=RUN, fwd_* <=0.
  - Otherwise wait_cnt increments by 1 per cycle; width 8 bits, no wrap possible given TIMEOUT<=255.
- Reset asserted mid-stall: immediate return to reset values; no pending bubble or forward survives.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined: stall_cycles increments by 1 every cycle in which stall_pc=1, saturating at 16'hFFFF; cleared only by reset.
- Undefined: no counter register is built; stall_cycles is driven constant 0.

Test Plan:
- ex_load=1, ex_valid=1, ex_rd=7, id_ra=7, id_ra_used=1, id_rb=1 -> same cycle stall_pc=stall_ifid=flush_idex=1; next cycle state LU_BUBBLE with fwd_a_mem=1, fwd_b_mem=0; cycle after, fwd_a_mem=0.
- ex_rd=1, id_rb=1 used, id_ra=7, load=1 -> fwd_b_mem=1, fwd_a_mem=0. Repeat with ex_load=0 -> no stall, fwd both 0.
- Hazard ex_rd=5=id_ra with id_ra_used=0 -> no stall. Hazard and branch_taken in the same cycle -> only flush_ifid=flush_idex=1, stall_pc=0.
- In LU_BUBBLE, mem_req=1, mem_ready=0 for 3 cycles then 1 -> all stall_* high for 3 cycles, fwd_a_mem held; release returns to LU_BUBBLE, then RUN.
- mem_req=1, mem_ready=0 held 20 cycles, TIMEOUT=15 -> mem_err=1 after 15 wait cycles, stalls release, state RUN; mem_err stays 1 until rst_n pulse low.
- With HAZARD_STALL_COUNT_EN: 1 load-use plus a 3-cycle mem wait -> stall_cycles=4; async reset mid-wait -> all outputs 0 immediately.
